// File: rtl/idct_block_engine.sv
// idct_block_engine: 8x8 two-pass integer inverse DCT over a host-loaded coefficient block.
// PASS1 forms T = S x C, PASS2 forms P = Ct x T, and OUTPUT streams 32 two-pixel words.
// Optional build macro IDCT_ROUND_EN adds round-half-up constants before both shifts.
module idct_block_engine #(
    parameter int COEF_W = 16,
    parameter int OUT_W  = 8,
    parameter int MULT_N = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic                     coef_we,
    input  logic [5:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*OUT_W-1:0]       out_data,
    output logic                     out_last,
    output logic                     done
);

    localparam int PASS_LEN = 512 / MULT_N;
    localparam int CH       = 8 / MULT_N;
    localparam int CHB      = $clog2(CH);
    localparam int MAXP     = (1 << OUT_W) - 1;
`ifdef IDCT_ROUND_EN
    localparam logic signed [31:0] RND1 = 32'sd128;
    localparam logic signed [31:0] RND2 = 32'sd32768;
`else
    localparam logic signed [31:0] RND1 = 32'sd0;
    localparam logic signed [31:0] RND2 = 32'sd0;
`endif

    typedef enum logic [2:0] {IDLE, PASS1, PASS2, OUTPUT, DONE} idctState_t;

    idctState_t              r_state, w_nextState;
    logic [9:0]              r_cnt;
    logic signed [COEF_W-1:0] r_sBuf [64];
    logic signed [31:0]      r_tBuf [64];
    logic [OUT_W-1:0]        r_pBuf [64];
    logic signed [31:0]      r_prod [MULT_N];
    logic                    r_p1Valid, r_p1First, r_p1Last;
    logic [5:0]              r_p1Elem;
    logic signed [31:0]      r_acc;
    logic [4:0]              r_word;
    logic                    r_outValid, r_outLast;
    logic [2*OUT_W-1:0]      r_outData;

    logic                    w_issue;
    logic [5:0]              w_elem;
    logic [2:0]              w_chunk;
    logic signed [31:0]      w_prod [MULT_N];
    logic signed [31:0]      w_sum, w_shift1, w_shift2;
    logic [OUT_W-1:0]        w_pix;
    logic [4:0]              w_loadWord;

    // DCT basis scaled by 2^12: row u, column x; row 0 is the flat DC basis.
    function automatic logic signed [15:0] cosC(input logic [2:0] u, input logic [2:0] x);
        logic [4:0]         m;
        logic               neg;
        logic signed [15:0] mag;
        m   = 5'({2'b00, x, 1'b1} * {2'b00, u});
        neg = 1'b0;
        if (m > 5'd16) m = 5'(~m + 5'd1);
        if (m > 5'd8) begin
            neg = 1'b1;
            m   = 5'd16 - m;
        end
        case (m)
            5'd0:    mag = 16'sd2048;
            5'd1:    mag = 16'sd2009;
            5'd2:    mag = 16'sd1892;
            5'd3:    mag = 16'sd1703;
            5'd4:    mag = 16'sd1448;
            5'd5:    mag = 16'sd1138;
            5'd6:    mag = 16'sd784;
            5'd7:    mag = 16'sd400;
            default: mag = 16'sd0;
        endcase
        if (u == 3'd0) return 16'sd1448;
        return neg ? -mag : mag;
    endfunction

    // Operand fetch and MULT_N parallel products for the current issue slot, then accumulation and rescaling.
    always_comb begin
        logic [2:0]         k;
        logic signed [31:0] a, b;
        w_issue = ((r_state == PASS1) || (r_state == PASS2)) && (r_cnt < 10'(PASS_LEN));
        w_elem  = 6'(r_cnt >> CHB);
        w_chunk = 3'(r_cnt & 10'(CH - 1));
        k = 3'd0;
        a = 32'sd0;
        b = 32'sd0;
        for (int m = 0; m < MULT_N; m++) begin
            k = 3'(w_chunk * MULT_N + m);
            if (r_state == PASS1) begin
                a = 32'(r_sBuf[{w_elem[5:3], k}]);
                b = 32'(cosC(k, w_elem[2:0]));
            end else begin
                a = r_tBuf[{k, w_elem[2:0]}];
                b = 32'(cosC(k, w_elem[5:3]));
            end
            w_prod[m] = a * b;
        end
        w_sum = r_p1First ? 32'sd0 : r_acc;
        for (int m = 0; m < MULT_N; m++) w_sum = w_sum + r_prod[m];
        w_shift1 = (w_sum + RND1) >>> 8;
        w_shift2 = (w_sum + RND2) >>> 16;
        if (w_shift2 < 0)         w_pix = '0;
        else if (w_shift2 > MAXP) w_pix = OUT_W'(MAXP);
        else                      w_pix = OUT_W'(w_shift2);
    end

    // Product register stage and running accumulator for the element being summed.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_p1Valid <= 1'b0;
            r_p1First <= 1'b0;
            r_p1Last  <= 1'b0;
            r_p1Elem  <= '0;
            r_acc     <= '0;
            for (int m = 0; m < MULT_N; m++) r_prod[m] <= '0;
        end else begin
            r_p1Valid <= w_issue;
            r_p1First <= (w_chunk == 3'd0);
            r_p1Last  <= (w_chunk == 3'(CH - 1));
            r_p1Elem  <= w_elem;
            for (int m = 0; m < MULT_N; m++) r_prod[m] <= w_prod[m];
            if (r_p1Valid) r_acc <= w_sum;
        end
    end

    // Coefficient, intermediate and pixel buffers; host writes accepted only while idle.
    always_ff @(posedge Clock) begin
        if ((r_state == IDLE) && coef_we) r_sBuf[coef_addr] <= coef_data;
        if (r_p1Valid && r_p1Last && (r_state == PASS1)) r_tBuf[r_p1Elem] <= w_shift1;
        if (r_p1Valid && r_p1Last && (r_state == PASS2)) r_pBuf[r_p1Elem] <= w_pix;
    end

    // Next-state decode: each pass runs a fixed cycle count, output ends on the last accepted word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = PASS1;
            PASS1:   if (r_cnt == 10'(PASS_LEN + 1)) w_nextState = PASS2;
            PASS2:   if (r_cnt == 10'(PASS_LEN + 1)) w_nextState = OUTPUT;
            OUTPUT:  if (r_outValid && out_ready && r_outLast) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register and pass cycle counter, cleared on every state change.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) r_cnt <= '0;
            else if ((r_state == PASS1) || (r_state == PASS2)) r_cnt <= r_cnt + 10'd1;
        end
    end

    assign w_loadWord = r_outValid ? (r_word + 5'd1) : 5'd0;

    // Output word register: first word loads on OUTPUT entry, later words load on each handshake.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_word     <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else if (r_state == OUTPUT) begin
            if (!r_outValid || (out_ready && !r_outLast)) begin
                r_word     <= w_loadWord;
                r_outValid <= 1'b1;
                r_outLast  <= (w_loadWord == 5'd31);
                r_outData  <= {r_pBuf[{w_loadWord, 1'b0}], r_pBuf[{w_loadWord, 1'b1}]};
            end else if (out_ready) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
                r_outData  <= '0;
            end
        end else begin
            r_word     <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign out_data  = r_outData;

endmodule

// File: tb/tb_idct_block_engine.sv
// tb_idct_block_engine: scoreboard bench for idct_block_engine using DC-only blocks.
module tb_idct_block_engine;

    localparam int COEF_W      = 16;
    localparam int OUT_W       = 8;
    localparam int MULT_N      = 4;
    localparam int PASS_CYC    = 512 / MULT_N + 2;
    localparam int FIRST_VALID = 2 * PASS_CYC + 1;
`ifdef IDCT_ROUND_EN
    localparam int DC512_PIX = 64;
`else
    localparam int DC512_PIX = 63;
`endif

    logic                     Clock;
    logic                     Resetn;
    logic                     start;
    logic                     coef_we;
    logic [5:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*OUT_W-1:0]       out_data;
    logic                     out_last;
    logic                     done;

    int testsRun    = 0;
    int testsFailed = 0;
    int blockWords  = 0;
    int cycCnt      = 0;
    int lastHsCyc   = 0;
    bit stallMode   = 0;
    logic               heldValid = 1'b0;
    logic [2*OUT_W:0]   heldWord;
    logic [2*OUT_W:0]   expWord;
    logic [2*OUT_W:0]   expQ [$];

    idct_block_engine #(.COEF_W(COEF_W), .OUT_W(OUT_W), .MULT_N(MULT_N)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Consumer ready: always high, or randomly throttled while stallMode is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            out_ready = stallMode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compares each accepted word against the scoreboard and checks hold during stalls.
    always @(negedge Clock) begin
        if (Resetn) begin
            if (heldValid && out_valid)
                checkOutput("stall hold", 32'({out_last, out_data}), 32'(heldWord));
            heldValid = 1'b0;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra word queue depth", 32'(expQ.size()), 32'd1);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("word", 32'({out_last, out_data}), 32'(expWord));
                end
                blockWords++;
                lastHsCyc = cycCnt;
            end else if (out_valid) begin
                heldValid = 1'b1;
                heldWord  = {out_last, out_data};
            end
        end else begin
            heldValid = 1'b0;
        end
    end

    // Loads a full block with only the DC coefficient non-zero.
    task automatic applyStimulus(input int dc);
        for (int a = 0; a < 64; a++) begin
            coef_we   = 1'b1;
            coef_addr = 6'(a);
            coef_data = (a == 0) ? COEF_W'(dc) : '0;
            @(posedge Clock);
            #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic pushBlock(input int pix);
        logic [2*OUT_W:0] w;
        for (int i = 0; i < 32; i++) begin
            w = {(i == 31), OUT_W'(pix), OUT_W'(pix)};
            expQ.push_back(w);
        end
    endtask

    task automatic runBlock(input int pix, input bit timing, input bit disturb);
        int cyc;
        blockWords = 0;
        pushBlock(pix);
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 2000) begin
            if (disturb && cyc == PASS_CYC + 20) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 6'd0;
                coef_data = COEF_W'(100);
            end
            @(posedge Clock);
            #1;
            cyc++;
            start   = 1'b0;
            coef_we = 1'b0;
        end
        checkOutput("first valid", 32'(out_valid), 32'd1);
        if (timing) checkOutput("first valid latency", 32'(cyc), 32'(FIRST_VALID));
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        checkOutput("done seen", 32'(done), 32'd1);
        if (timing) checkOutput("done after last handshake", 32'(cycCnt - lastHsCyc), 32'd1);
        checkOutput("word count", 32'(blockWords), 32'd32);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        @(posedge Clock);
        #1;
        checkOutput("done single cycle", 32'(done), 32'd0);
        checkOutput("idle after done", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        Resetn    = 1'b0;
        start     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_last", 32'(out_last), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        $display("[TB] DC=512 with continuous ready");
        applyStimulus(512);
        runBlock(DC512_PIX, 1'b1, 1'b0);

        $display("[TB] DC=-512 with random ready stalls");
        applyStimulus(-512);
        stallMode = 1'b1;
        runBlock(0, 1'b0, 1'b0);
        stallMode = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        $display("[TB] DC=4000 with start/coef_we pulses during PASS2, then repeat without reload");
        applyStimulus(4000);
        runBlock(255, 1'b0, 1'b1);
        runBlock(255, 1'b0, 1'b0);

        $display("[TB] reset during output word 10");
        applyStimulus(512);
        blockWords = 0;
        pushBlock(DC512_PIX);
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        cyc = 0;
        while (blockWords < 10 && cyc < 3000) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        checkOutput("reached word 10", 32'(blockWords), 32'd10);
        Resetn = 1'b0;
        #1;
        checkOutput("mid-output reset busy", 32'(busy), 32'd0);
        checkOutput("mid-output reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid-output reset out_data", 32'(out_data), 32'd0);
        expQ.delete();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        applyStimulus(512);
        runBlock(DC512_PIX, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
